tx_fifo_shifter: RTL

TX_FIFO_SHIFTER -- requirements
Module: tx_fifo_shifter

---
 rtl/tx_fifo_shifter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tx_fifo_shifter.sv
// tx_fifo_shifter: a small transmit FIFO that feeds an output shift register (OSR).
// The OSR is loaded directly (mov_en), by an explicit pull from the FIFO head
// (pull_req), or by an automatic refill once enough bits have been shifted out.
// Define TX_FIFO_SHIFTER_AUTOPULL_EN to compile in the autopull refill logic;
// without it autopull and pull_thresh are ignored.
module tx_fifo_shifter #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(WIDTH) + 1,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] mov_in,
    input  logic             mov_en,
    input  logic             pull_req,
    input  logic             shift_en,
    input  logic             shiftdir,
    input  logic [CW-2:0]    shift_count,
    input  logic [CW-2:0]    pull_thresh,
    input  logic             autopull,
    output logic [WIDTH-1:0] data_out,
    output logic             stall,
    output logic             fifo_pulled,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [LW-1:0]    fifo_level,
    output logic             overflow,
    output logic [CW-1:0]    output_shift_counter
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(WIDTH);
    localparam logic [LW-1:0]   DEPTH_L    = LW'(DEPTH);

    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] osr;

    logic [CW-1:0]    shift_n;
    logic             auto_cond;
    logic             do_push;
    logic             do_pop;
    logic             do_load_mov;
    logic             do_shift;
    logic [WIDTH-1:0] shift_mask;
    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] shift_osr;
    logic [CW:0]      count_sum;
    logic [CW-1:0]    count_next;

    assign fifo_full  = (fifo_level == DEPTH_L);
    assign fifo_empty = (fifo_level == '0);

    // A zero shift count means a full-width shift.
    assign shift_n = (shift_count == '0) ? FULL_COUNT : {1'b0, shift_count};

`ifdef TX_FIFO_SHIFTER_AUTOPULL_EN
    logic [CW-1:0] thresh_n;
    assign thresh_n  = (pull_thresh == '0) ? FULL_COUNT : {1'b0, pull_thresh};
    assign auto_cond = autopull && (output_shift_counter >= thresh_n);
`else
    logic unused_autopull;
    assign unused_autopull = autopull ^ (^pull_thresh);
    assign auto_cond       = 1'b0;
`endif

    // A push is refused whenever the FIFO is full, regardless of a same-cycle pop.
    assign do_push = wr_en && !fifo_full;

    // Per-cycle OSR arbitration: direct load, then pull, then autopull refill, then shift.
    always_comb begin
        stall       = 1'b0;
        do_load_mov = 1'b0;
        do_pop      = 1'b0;
        do_shift    = 1'b0;
        if (mov_en) begin
            do_load_mov = 1'b1;
        end else if (pull_req) begin
            if (fifo_empty) begin
                stall = 1'b1;
            end else begin
                do_pop = 1'b1;
            end
        end else if (auto_cond) begin
            stall  = shift_en;
            do_pop = !fifo_empty;
        end else if (shift_en) begin
            do_shift = 1'b1;
        end
    end

    // Shift datapath: extract n bits from the chosen end and advance the saturating counter.
    always_comb begin
        shift_mask = ~({WIDTH{1'b1}} << shift_n);
        if (shiftdir) begin
            shift_out = osr & shift_mask;
            shift_osr = osr >> shift_n;
        end else begin
            shift_out = osr >> (FULL_COUNT - shift_n);
            shift_osr = osr << shift_n;
        end
        count_sum  = {1'b0, output_shift_counter} + {1'b0, shift_n};
        count_next = (count_sum > {1'b0, FULL_COUNT}) ? FULL_COUNT : count_sum[CW-1:0];
    end

    // OSR, shifted output, consumed-bit counter and pop pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            osr                  <= '0;
            data_out             <= '0;
            output_shift_counter <= FULL_COUNT;
            fifo_pulled          <= 1'b0;
        end else begin
            fifo_pulled <= do_pop;
            if (do_load_mov) begin
                osr                  <= mov_in;
                output_shift_counter <= '0;
            end else if (do_pop) begin
                osr                  <= fifo_mem[rd_ptr];
                output_shift_counter <= '0;
            end else if (do_shift) begin
                osr                  <= shift_osr;
                data_out             <= shift_out;
                output_shift_counter <= count_next;
            end
        end
    end

    // FIFO storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
